// File: rtl/ahb_frame_sequencer.sv
// Round-robin two-requester front end for the mapper serial link: latches the
// winner's AHB fields into a 100-bit frame, shifts it MSB-first, then idles.
module ahb_frame_sequencer #(
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic             req0_hwrite,
    input  logic [1:0]       req0_htrans,
    input  logic [31:0]      req0_haddr,
    input  logic [31:0]      req0_hwdata,
    input  logic [31:0]      req0_prdata,
    input  logic             req1_hwrite,
    input  logic [1:0]       req1_htrans,
    input  logic [31:0]      req1_haddr,
    input  logic [31:0]      req1_hwdata,
    input  logic [31:0]      req1_prdata,
    output logic             data_to_mapper,
    output logic             frame_active,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic [CNT_W-1:0] frame_count
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0] G_PRE  = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state;
    logic [99:0]   shreg;
    logic [6:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          last_owner;   // 1 = req1 was granted last

    logic          accept;
    logic          win1;
    logic [1:0]    win_oh;
    logic          done_next;
    logic [99:0]   frame0;
    logic [99:0]   frame1;

    assign frame0 = {req0_hwrite, 1'b1, req0_htrans, req0_haddr, req0_hwdata, req0_prdata};
    assign frame1 = {req1_hwrite, 1'b1, req1_htrans, req1_haddr, req1_hwdata, req1_prdata};

    // Shift register drains to zero after 100 shifts, so the line idles low.
    assign data_to_mapper = shreg[99];

    always_comb begin
        accept    = (state == IDLE) && enable && (req_valid != 2'b00);
        win1      = req_valid[1] && (!req_valid[0] || !last_owner);
        win_oh    = win1 ? 2'b10 : 2'b01;
        req_ready = accept ? win_oh : 2'b00;
        // Asserted in the cycle before the last cycle of the frame period.
        if (GAP_CYCLES == 0)
            done_next = (state == SHIFT) && (bit_cnt == 7'd98);
        else if (GAP_CYCLES == 1)
            done_next = (state == SHIFT) && (bit_cnt == 7'd99);
        else
            done_next = (state == GAP) && (gap_cnt == G_PRE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            last_owner   <= 1'b1;
            frame_active <= 1'b0;
            grant        <= 2'b00;
            done         <= 2'b00;
            frame_count  <= '0;
        end else begin
            done <= done_next ? grant : 2'b00;
            if (done_next)
                frame_count <= frame_count + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg        <= win1 ? frame1 : frame0;
                        grant        <= win_oh;
                        last_owner   <= win1;
                        bit_cnt      <= '0;
                        frame_active <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[98:0], 1'b0};
                    bit_cnt <= bit_cnt + 7'd1;
                    if (bit_cnt == 7'd99) begin
                        frame_active <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            grant <= 2'b00;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_cnt == G_LAST) begin
                        grant <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_frame_sequencer.sv
// Directed bench: table of single-frame transfers plus hand sequences for
// round-robin spacing, enable drop, mid-frame reset and zero-gap back-to-back.
module tb_ahb_frame_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable, z_enable;
    logic [1:0]  req_valid, z_valid;
    logic        r0_w, r1_w;
    logic [1:0]  r0_t, r1_t;
    logic [31:0] r0_a, r0_d, r0_p, r1_a, r1_d, r1_p;
    logic [1:0]  req_ready, grant, done, z_ready, z_grant, z_done;
    logic        data_to_mapper, frame_active, z_data, z_active;
    logic [15:0] frame_count, z_count;

    ahb_frame_sequencer #(.GAP_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .req_valid(req_valid),
        .req_ready(req_ready),
        .req0_hwrite(r0_w), .req0_htrans(r0_t), .req0_haddr(r0_a),
        .req0_hwdata(r0_d), .req0_prdata(r0_p),
        .req1_hwrite(r1_w), .req1_htrans(r1_t), .req1_haddr(r1_a),
        .req1_hwdata(r1_d), .req1_prdata(r1_p),
        .data_to_mapper(data_to_mapper), .frame_active(frame_active),
        .grant(grant), .done(done), .frame_count(frame_count));

    ahb_frame_sequencer #(.GAP_CYCLES(0), .CNT_W(16)) dutz (
        .clk(clk), .reset_n(reset_n), .enable(z_enable), .req_valid(z_valid),
        .req_ready(z_ready),
        .req0_hwrite(r0_w), .req0_htrans(r0_t), .req0_haddr(r0_a),
        .req0_hwdata(r0_d), .req0_prdata(r0_p),
        .req1_hwrite(r1_w), .req1_htrans(r1_t), .req1_haddr(r1_a),
        .req1_hwdata(r1_d), .req1_prdata(r1_p),
        .data_to_mapper(z_data), .frame_active(z_active),
        .grant(z_grant), .done(z_done), .frame_count(z_count));

    typedef struct {
        logic [1:0]  valid;
        logic        w0;
        logic [1:0]  t0;
        logic [31:0] a0, d0, p0;
        logic        w1;
        logic [1:0]  t1;
        logic [31:0] a1, d1, p1;
        logic [1:0]  exp_ready;
        logic [99:0] exp_frame;
    } vec_t;

    vec_t vecs[5];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int limit, output logic [1:0] rdy, output int at);
        logic hit;
        hit = 1'b0;
        rdy = 2'b00;
        at  = -1000;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) begin
                rdy = req_ready;
                at  = cyc;
                hit = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int limit, output logic [1:0] d, output int at);
        logic hit;
        hit = 1'b0;
        d   = 2'b00;
        at  = -1000;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            if (done !== 2'b00) begin
                d   = done;
                at  = cyc;
                hit = 1'b1;
            end
        end
    endtask

    task automatic set_fields(input vec_t v);
        r0_w = v.w0; r0_t = v.t0; r0_a = v.a0; r0_d = v.d0; r0_p = v.p0;
        r1_w = v.w1; r1_t = v.t1; r1_a = v.a1; r1_d = v.d1; r1_p = v.p1;
    endtask

    initial begin
        logic [1:0]  rdy, d;
        logic [99:0] cap;
        int          t, td, prev, errs;

        vecs[0] = '{2'b01, 1'b0, 2'b00, 32'h8000000C, 32'hFFFFFFFF, 32'h56781234,
                    1'b1, 2'b11, 32'h11111111, 32'h22222222, 32'h33333333,
                    2'b01, 100'h4_8000000C_FFFFFFFF_56781234};
        vecs[1] = '{2'b10, 1'b1, 2'b11, 32'h0BADF00D, 32'h0, 32'h0,
                    1'b1, 2'b10, 32'hDEADBEEF, 32'h01234567, 32'h00000000,
                    2'b10, 100'hE_DEADBEEF_01234567_00000000};
        vecs[2] = '{2'b11, 1'b1, 2'b11, 32'h00000000, 32'hA5A5A5A5, 32'hFFFFFFFF,
                    1'b0, 2'b01, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
                    2'b01, 100'hF_00000000_A5A5A5A5_FFFFFFFF};
        vecs[3] = '{2'b11, 1'b1, 2'b11, 32'hCAFEBABE, 32'h1, 32'h2,
                    1'b0, 2'b01, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
                    2'b10, 100'h5_12345678_9ABCDEF0_0F0F0F0F};
        vecs[4] = '{2'b01, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                    1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    2'b01, 100'h4_00000000_00000000_00000000};

        reset_n = 1'b0; enable = 1'b0; z_enable = 1'b0;
        req_valid = 2'b00; z_valid = 2'b00;
        set_fields(vecs[0]);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {data_to_mapper, frame_active, grant, done, req_ready},
            {1'b0, 1'b0, 2'b00, 2'b00, 2'b00});
        chk("reset_count", frame_count, 16'd0);

        // enable low: no accepts even with both requests pending
        step();
        req_valid = 2'b11;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00 || data_to_mapper !== 1'b0 || grant !== 2'b00) errs++;
        end
        chk("enable_low_idle", errs, 0);
        step();
        req_valid = 2'b00;
        enable = 1'b1;

        for (int n = 0; n < 5; n++) begin
            step();
            set_fields(vecs[n]);
            req_valid = vecs[n].valid;
            wait_ready(50, rdy, t);
            chk($sformatf("v%0d_ready", n), rdy, vecs[n].exp_ready);
            step();
            req_valid = 2'b00;
            r0_a = ~r0_a; r0_d = ~r0_d; r0_w = ~r0_w;
            r1_a = ~r1_a; r1_p = ~r1_p; r1_t = ~r1_t;
            errs = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                cap[99-k] = data_to_mapper;
                if (frame_active !== 1'b1 || grant !== vecs[n].exp_ready) errs++;
            end
            chk($sformatf("v%0d_frame", n), cap, vecs[n].exp_frame);
            chk($sformatf("v%0d_shift_active_grant", n), errs, 0);
            errs = 0;
            for (int g = 1; g <= 4; g++) begin
                @(negedge clk);
                if (data_to_mapper !== 1'b0 || frame_active !== 1'b0 ||
                    grant !== vecs[n].exp_ready) errs++;
                if (g < 4 && done !== 2'b00) errs++;
                if (g == 4) chk($sformatf("v%0d_done_T104", n), done, vecs[n].exp_ready);
            end
            chk($sformatf("v%0d_gap", n), errs, 0);
            @(negedge clk);
            chk($sformatf("v%0d_after_done", n), {grant, done}, 4'b0000);
            chk($sformatf("v%0d_count", n), frame_count, 16'(n + 1));
        end

        // reset mid-frame around shift bit 40
        step();
        set_fields(vecs[0]);
        req_valid = 2'b01;
        wait_ready(50, rdy, t);
        chk("rst_frame_ready", rdy, 2'b01);
        step();
        req_valid = 2'b00;
        repeat (40) @(negedge clk);
        step();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {data_to_mapper, frame_active, grant, done},
            {1'b0, 1'b0, 2'b00, 2'b00});
        chk("rst_mid_count", frame_count, 16'd0);
        step();
        step();
        reset_n = 1'b1;

        // both valid continuously: 01,10,01 at 105-cycle spacing
        step();
        req_valid = 2'b11;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_ready(200, rdy, t);
            chk($sformatf("rr%0d_ready", i), rdy, (i % 2) ? 2'b10 : 2'b01);
            if (i > 0) chk($sformatf("rr%0d_spacing", i), t - prev, 105);
            prev = t;
            wait_done(200, d, td);
            chk($sformatf("rr%0d_done", i), d, (i % 2) ? 2'b10 : 2'b01);
            chk($sformatf("rr%0d_done_time", i), td - t, 104);
        end
        step();
        req_valid = 2'b00;

        // enable dropped at shift bit 50; req1 due after 0,1,0
        step();
        req_valid = 2'b11;
        wait_ready(50, rdy, t);
        chk("en_drop_ready", rdy, 2'b10);
        repeat (50) @(negedge clk);
        step();
        enable = 1'b0;
        wait_done(200, d, td);
        chk("en_drop_done", d, 2'b10);
        chk("en_drop_done_time", td - t, 104);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00 || grant !== 2'b00 || frame_active !== 1'b0) errs++;
        end
        chk("en_drop_hold_idle", errs, 0);
        chk("en_drop_count", frame_count, 16'd4);
        step();
        req_valid = 2'b00;

        // zero gap: done in last shift cycle, next accept right after
        step();
        z_valid = 2'b11;
        z_enable = 1'b1;
        t = -1000;
        for (int i = 0; i < 50 && t < 0; i++) begin
            @(negedge clk);
            if (z_ready !== 2'b00) begin rdy = z_ready; t = cyc; end
        end
        chk("z_first_ready", rdy, 2'b01);
        td = -1000;
        for (int i = 0; i < 200 && td < 0; i++) begin
            @(negedge clk);
            if (z_done !== 2'b00) begin
                d = z_done; td = cyc;
                chk("z_done_in_shift", z_active, 1'b1);
            end
        end
        chk("z_done", d, 2'b01);
        chk("z_done_time", td - t, 100);
        prev = t;
        t = -1000;
        rdy = 2'b00;
        for (int i = 0; i < 50 && t < 0; i++) begin
            @(negedge clk);
            if (z_ready !== 2'b00) begin rdy = z_ready; t = cyc; end
        end
        chk("z_second_ready", rdy, 2'b10);
        chk("z_period", t - prev, 101);
        chk("z_count", z_count, 16'd1);
        step();
        z_valid = 2'b00;
        z_enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
